fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one fifo_sync write port among NUM_REQ
//  valid/ready producers. Grants one producer a burst of up to MAX_BURST words,
//  then re-arbitrates. Gates every write on fifo full, so the FIFO never overflows.
//  Sits between producer cores and fifo_sync (wr_data/wr_en/full).
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  DATA_WIDTH 16  word width, matches fifo_sync DATA_WIDTH
//  MAX_BURST  4   max words per grant (>=1); counter width $clog2(MAX_BURST+1)
// PORTS
//  clk          in   1                   clock, all logic rising-edge
//  reset        in   1                   synchronous, active-high
//  req_valid    in   NUM_REQ             per-requester word valid
//  req_last     in   NUM_REQ             per-requester end-of-burst flag, qualified by valid
//  req_data     in   NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready    out  NUM_REQ             one-hot or zero; word accepted when valid&ready
//  fifo_wr_data out  DATA_WIDTH          to fifo_sync wr_data
//  fifo_wr_en   out  1                   to fifo_sync wr_en
//  fifo_full    in   1                   from fifo_sync full
//  grant_valid  out  1                   high while in GRANT
//  grant_id     out  $clog2(NUM_REQ)     current/last granted requester
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0, fifo_wr_en=0, grant_valid=0, grant_id=0,
//   burst_cnt=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
//   Reset mid-burst aborts the burst; no write occurs in the reset cycle.
//  FSM IDLE:
//   - req_ready=0, fifo_wr_en=0.
//   - If any req_valid: choose the first set bit scanning last_grant+1,
//     last_grant+2, ... modulo NUM_REQ (last_grant itself is scanned last).
//     Register it into grant_id, burst_cnt<=0, go GRANT. Arbitration latency 1 cycle.
//   - No req_valid: stay IDLE.
//  FSM GRANT (g=grant_id):
//   - req_ready[g] = ~fifo_full (combinational); all other ready bits 0.
//   - xfer = req_valid[g] & ~fifo_full; fifo_wr_en = xfer;
//     fifo_wr_data = req_data[g] (combinational, zero-latency pass-through).
//   - On xfer: burst_cnt++.
//   - Release, i.e. go IDLE with last_grant<=g, when any of:
//     (a) xfer & req_last[g]; (b) xfer & burst_cnt==MAX_BURST-1;
//     (c) ~req_valid[g] (requester dropped, no word this cycle).
//   - fifo_full high: no write and no release from (a)/(b); grant is held and
//     burst_cnt frozen. (c) still applies.
//  Between bursts there is exactly one IDLE cycle (bus idle, no write).
//  fifo_wr_en is never high while fifo_full is high, under any input.
//  grant_id holds its last value in IDLE; grant_valid = (state==GRANT).
//  Simultaneous requests: round-robin only; no requester waits more than
//   NUM_REQ-1 grants.
// TESTING
//  1 Reset: reset=1 for 2 cycles with all req_valid=1 -> req_ready=0,
//    fifo_wr_en=0, grant_id=0; first grant after release goes to req 0.
//  2 Round robin: req_valid=4'b1111, req_last=1 on every word -> grants 0,1,2,3,0,
//    one word each, one IDLE cycle between grants, FIFO receives words in that order.
//  3 Burst cap: req 2 streams 10 words, req_last=0, others idle -> bursts of 4,4,2
//    (last ends on valid drop), each separated by one IDLE cycle.
//  4 Full backpressure: mid-burst hold fifo_full=1 for 3 cycles -> fifo_wr_en=0,
//    req_ready=0, grant_id and burst_cnt unchanged; resume with no word lost or duplicated.
//  5 Drop/last: req 1 asserts req_last on 2nd word -> release after 2 writes;
//    req 3 drops valid after 1 word -> release next cycle, no write.
//  6 Reset mid-burst after 2 of 4 words -> outputs return to reset values next
//    cycle; no write in reset cycle; arbitration restarts from req 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request bus and fifo_sync write port shared by the write arbiter.
// The slave modport is the arbiter's view; master is the producer/FIFO environment.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_en;
  logic                          fifo_full;
  logic                          grant_valid;
  logic [IDW-1:0]                grant_id;

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr_data, fifo_wr_en, grant_valid, grant_id
  );

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_data, fifo_wr_en, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter: grants one producer up to MAX_BURST words
// into a shared fifo_sync write port, never writing while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic            clk,
  input  logic            reset,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                state, state_n;
  logic [IDW-1:0]        grant_id, grant_id_n;
  logic [IDW-1:0]        last_grant, last_grant_n;
  logic [IDW-1:0]        pick;
  logic [CW-1:0]         burst_cnt, burst_cnt_n;
  logic                  any_valid, xfer, cap_hit;
  logic [NUM_REQ-1:0]    ready;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Two descending scans so the lowest index wins in each region; requesters
  // above last_grant override the wrapped region, giving rotating priority.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    for (int c = NUM_REQ-1; c >= 0; c--) begin
      if (bus.req_valid[c] && (c <= int'(last_grant))) begin
        pick      = IDW'(c);
        any_valid = 1'b1;
      end
    end
    for (int c = NUM_REQ-1; c >= 0; c--) begin
      if (bus.req_valid[c] && (c > int'(last_grant))) begin
        pick      = IDW'(c);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    grant_id_n   = grant_id;
    last_grant_n = last_grant;
    burst_cnt_n  = burst_cnt;
    ready        = '0;
    xfer         = 1'b0;
    cap_hit      = (burst_cnt == CW'(MAX_BURST - 1));
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant_id_n  = pick;
          burst_cnt_n = '0;
          state_n     = GRANT;
        end
      end
      GRANT: begin
        ready[grant_id] = ~bus.fifo_full;
        xfer            = bus.req_valid[grant_id] & ~bus.fifo_full;
        if (xfer) burst_cnt_n = burst_cnt + CW'(1);
        // full blocks last/cap release, but a dropped valid still releases
        if ((xfer && (bus.req_last[grant_id] || cap_hit)) || !bus.req_valid[grant_id]) begin
          state_n      = IDLE;
          last_grant_n = grant_id;
        end
      end
      default: state_n = IDLE;
    endcase
    // the reset cycle must not hand-shake or write, even mid-burst
    if (reset) begin
      ready = '0;
      xfer  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_n;
      grant_id   <= grant_id_n;
      last_grant <= last_grant_n;
      burst_cnt  <= burst_cnt_n;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = xfer;
  assign bus.fifo_wr_data = words[grant_id];
  assign bus.grant_valid  = (state == GRANT);
  assign bus.grant_id     = grant_id;

  a_no_overflow: assert property (@(posedge clk) !(bus.fifo_wr_en && bus.fifo_full));
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queue-fed producers, a cycle-level
// reference model checked every cycle, and literal write-log expectations.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // producer word queues
  logic [DW-1:0] wdat [N][32];
  logic          wl   [N][32];
  int            hd [N];
  int            tl [N];

  // observed write log and expected log
  logic [DW-1:0] wlog_d [64];
  int            wlog_g [64];
  int            wlog_c [64];
  int            nlog = 0;
  logic [DW-1:0] exp_d [64];
  int            exp_g [64];
  int            exp_gap [64];
  int            ne = 0;
  int            cyc = 0;
  bit            started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic add_word(input int i, input logic [DW-1:0] d, input logic l);
    wdat[i][tl[i]] = d;
    wl[i][tl[i]]   = l;
    tl[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]          = (hd[i] < tl[i]);
      bus.req_last[i]           = (hd[i] < tl[i]) ? wl[i][hd[i]] : 1'b0;
      bus.req_data[i*DW +: DW]  = (hd[i] < tl[i]) ? wdat[i][hd[i]] : '0;
    end
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    cyc++;
    if (bus.fifo_wr_en) begin
      wlog_d[nlog] = bus.fifo_wr_data;
      wlog_g[nlog] = int'(bus.grant_id);
      wlog_c[nlog] = cyc;
      nlog++;
    end
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) hd[i]++;
    drive();
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (hd[i] < tl[i]) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string nm);
    for (int t = 0; t < 300; t++) begin
      tick();
      if (all_empty() && !bus.grant_valid) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s drain timeout: queues not empty after 300 cycles", nm);
  endtask

  task automatic wait_writes(input string nm, input int n);
    for (int t = 0; t < 100; t++) begin
      if (nlog >= n) return;
      tick();
    end
    vectors++;
    miscompares++;
    $display("FAIL %s wait timeout: got %0d writes, expected %0d", nm, nlog, n);
  endtask

  task automatic clr();
    nlog = 0;
    ne   = 0;
  endtask

  task automatic ex(input logic [DW-1:0] d, input int g, input int gap);
    exp_d[ne]   = d;
    exp_g[ne]   = g;
    exp_gap[ne] = gap;
    ne++;
  endtask

  task automatic chk_log(input string nm);
    chk({nm, " nwrites"}, nlog, ne);
    for (int j = 0; j < nlog && j < ne; j++) begin
      chk($sformatf("%s data%0d", nm, j), wlog_d[j], exp_d[j]);
      chk($sformatf("%s gid%0d", nm, j), wlog_g[j], exp_g[j]);
      if (j > 0) chk($sformatf("%s gap%0d", nm, j), wlog_c[j] - wlog_c[j-1], exp_gap[j]);
    end
  endtask

  // Reference model: who owns the port, words taken in this grant, rr pointer.
  int m_owner = -1;
  int m_gid   = 0;
  int m_cnt   = 0;
  int m_last  = N - 1;

  initial begin
    @(posedge clk);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      logic [N-1:0] er;
      logic         ew;
      bit           found;
      int           idx;
      er = '0;
      ew = 1'b0;
      if (!reset && m_owner >= 0) begin
        er[m_owner] = !bus.fifo_full;
        ew          = bus.req_valid[m_owner] && !bus.fifo_full;
      end
      chk("cmp_ready", bus.req_ready, er);
      chk("cmp_wr_en", bus.fifo_wr_en, ew);
      chk("cmp_grant_valid", bus.grant_valid, m_owner >= 0);
      chk("cmp_grant_id", bus.grant_id, m_gid);
      if (ew) chk("cmp_wr_data", bus.fifo_wr_data, bus.req_data[m_owner*DW +: DW]);
      if (bus.fifo_wr_en && bus.fifo_full) chk("cmp_overflow", 1, 0);

      if (reset) begin
        m_owner = -1; m_gid = 0; m_cnt = 0; m_last = N - 1;
      end else if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && bus.req_valid[idx]) begin
            found = 1'b1; m_owner = idx; m_gid = idx; m_cnt = 0;
          end
        end
      end else begin
        if (ew) m_cnt++;
        if ((ew && (bus.req_last[m_owner] || m_cnt == MB)) || !bus.req_valid[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    reset = 1'b1;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    // reset with all requesters valid, then one-word bursts round robin
    add_word(0, 16'hA000, 1'b1);
    add_word(0, 16'hA001, 1'b1);
    add_word(1, 16'hA100, 1'b1);
    add_word(2, 16'hA200, 1'b1);
    add_word(3, 16'hA300, 1'b1);
    drive();
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("rst ready", bus.req_ready, 4'b0000);
      chk("rst wr_en", bus.fifo_wr_en, 1'b0);
      chk("rst grant_id", bus.grant_id, 2'd0);
      chk("rst grant_valid", bus.grant_valid, 1'b0);
    end
    chk("rst no writes", nlog, 0);
    reset = 1'b0;
    rel = cyc;
    clr();
    drain("rr");
    ex(16'hA000, 0, 0); ex(16'hA100, 1, 2); ex(16'hA200, 2, 2);
    ex(16'hA300, 3, 2); ex(16'hA001, 0, 2);
    chk_log("rr");
    chk("rr first latency", wlog_c[0], rel + 2);

    // burst cap: 10 words from req 2, no last
    clr();
    for (int k = 0; k < 10; k++) add_word(2, 16'h3200 + 16'(k), 1'b0);
    drive();
    drain("cap");
    for (int k = 0; k < 10; k++) ex(16'h3200 + 16'(k), 2, (k == 4 || k == 8) ? 2 : 1);
    chk_log("cap");

    // full backpressure for 3 cycles after 2 words
    clr();
    for (int k = 0; k < 6; k++) add_word(0, 16'h4000 + 16'(k), 1'b0);
    drive();
    wait_writes("full", 2);
    bus.fifo_full = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("full grant_valid", bus.grant_valid, 1'b1);
      chk("full grant_id", bus.grant_id, 2'd0);
      chk("full nwrites held", nlog, 2);
    end
    bus.fifo_full = 1'b0;
    drain("full");
    ex(16'h4000, 0, 0); ex(16'h4001, 0, 1); ex(16'h4002, 0, 4);
    ex(16'h4003, 0, 1); ex(16'h4004, 0, 2); ex(16'h4005, 0, 1);
    chk_log("full");

    // last on 2nd word of req 1; req 3 drops after 1 word
    clr();
    add_word(1, 16'h5100, 1'b0);
    add_word(1, 16'h5101, 1'b1);
    add_word(1, 16'h5102, 1'b1);
    add_word(3, 16'h5300, 1'b0);
    drive();
    drain("droplast");
    ex(16'h5100, 1, 0); ex(16'h5101, 1, 1); ex(16'h5300, 3, 2); ex(16'h5102, 1, 3);
    chk_log("droplast");

    // reset mid-burst after 2 of 4 words
    clr();
    for (int k = 0; k < 4; k++) add_word(2, 16'h6200 + 16'(k), k == 3);
    add_word(0, 16'h6000, 1'b1);
    drive();
    wait_writes("midrst", 2);
    reset = 1'b1;
    tick();
    chk("midrst no write", nlog, 2);
    chk("midrst grant_valid", bus.grant_valid, 1'b0);
    chk("midrst grant_id", bus.grant_id, 2'd0);
    chk("midrst ready", bus.req_ready, 4'b0000);
    reset = 1'b0;
    drain("midrst");
    ex(16'h6200, 2, 0); ex(16'h6201, 2, 1); ex(16'h6000, 0, 3);
    ex(16'h6202, 2, 2); ex(16'h6203, 2, 1);
    chk_log("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
